// File: rtl/wb_stage.sv
// Write-back stage: selects result source, registers one transaction, commits it to the register file and owns HI/LO.
// Optional forwarding outputs are compiled in when WB_BYPASS_EN is defined.
module wb_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        src_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] pc_link,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              reg_write,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic              rf_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
`ifdef WB_BYPASS_EN
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              err_sel
);

  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  logic              r_vld_p1;
  logic              r_wflag_p1;
  logic [ADDR_W-1:0] r_waddr_p1;
  logic [DATA_W-1:0] r_wdata_p1;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_err;

  logic              w_accept;
  logic              w_legal;
  logic [ADDR_W-1:0] w_waddr_p0;
  logic [DATA_W-1:0] w_wdata_p0;

  function automatic logic [DATA_W-1:0] sel_data(
    input logic [2:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] mem,
    input logic [DATA_W-1:0] hiv,
    input logic [DATA_W-1:0] lov,
    input logic [DATA_W-1:0] link
  );
    logic [DATA_W-1:0] d;
    d = '0;
    case (sel)
      3'b000:  d = alu;
      3'b001:  d = mem;
      3'b010:  d = hiv;
      3'b011:  d = lov;
      3'b100:  d = link;
      default: d = '0;
    endcase
    return d;
  endfunction

  assign in_ready   = !r_vld_p1 || !rf_stall;
  assign w_accept   = in_valid && in_ready;
  assign w_legal    = (src_sel <= 3'b100);
  // HI/LO are read from the registers before this edge's own hilo_we update
  assign w_wdata_p0 = sel_data(src_sel, alu_result, mem_dout, r_hi, r_lo, pc_link);
  assign w_waddr_p0 = (src_sel == 3'b100 && rd_addr == '0) ? LINK_A : rd_addr;

  // ---- p0 -> p1 boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_wflag_p1 <= 1'b0;
      r_waddr_p1 <= '0;
      r_wdata_p1 <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_vld_p1   <= 1'b1;
        r_wflag_p1 <= reg_write && w_legal;
        r_waddr_p1 <= w_waddr_p0;
        r_wdata_p1 <= w_wdata_p0;
        if (hilo_we) begin
          r_hi <= hi_in;
          r_lo <= lo_in;
        end
        if (!w_legal) r_err <= 1'b1;
      end else if (!rf_stall) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  assign rf_we    = r_vld_p1 && r_wflag_p1 && !rf_stall && (r_waddr_p1 != '0);
  assign rf_waddr = r_waddr_p1;
  assign rf_wdata = r_wdata_p1;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign err_sel  = r_err;

`ifdef WB_BYPASS_EN
  assign fwd_valid = r_vld_p1 && r_wflag_p1 && (r_waddr_p1 != '0);
  assign fwd_addr  = r_waddr_p1;
  assign fwd_data  = r_wdata_p1;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random traffic against a transaction-level model.
module tb_wb_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, in_valid, reg_write, hilo_we, rf_stall;
  logic          in_ready, rf_we, err_sel;
  logic [2:0]    src_sel;
  logic [DW-1:0] alu_result, mem_dout, pc_link, hi_in, lo_in;
  logic [AW-1:0] rd_addr, rf_waddr;
  logic [DW-1:0] rf_wdata, hi, lo;

  wb_stage #(.DATA_W(DW), .ADDR_W(AW), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src_sel(src_sel), .alu_result(alu_result), .mem_dout(mem_dout), .pc_link(pc_link),
    .rd_addr(rd_addr), .reg_write(reg_write), .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi(hi), .lo(lo), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_commits = 0;
  int dut_commits = 0;

  // Model: the one pending transaction plus architectural HI/LO/error state
  logic          m_pend, m_write, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_hi, m_lo;

  always @(posedge clk) if (rf_we === 1'b1) dut_commits++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_we();
    return m_pend && m_write && !rf_stall && (m_addr != 0);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, in_ready, !m_pend || !rf_stall);
    chk({tag, ".we"},    rf_we,    model_we());
    chk({tag, ".waddr"}, rf_waddr, m_addr);
    chk({tag, ".wdata"}, rf_wdata, m_data);
    chk({tag, ".hi"},    hi,       m_hi);
    chk({tag, ".lo"},    lo,       m_lo);
    chk({tag, ".err"},   err_sel,  m_err);
  endtask

  task automatic tick();
    logic          take;
    logic [DW-1:0] d;
    @(posedge clk);
    if (model_we()) exp_commits++;
    take = in_valid && (!m_pend || !rf_stall);
    if (rst) begin
      m_pend = 0; m_write = 0; m_err = 0; m_addr = 0; m_data = 0; m_hi = 0; m_lo = 0;
    end else if (take) begin
      case (src_sel)
        3'd0: d = alu_result;
        3'd1: d = mem_dout;
        3'd2: d = m_hi;
        3'd3: d = m_lo;
        3'd4: d = pc_link;
        default: d = 0;
      endcase
      m_data  = d;
      m_addr  = (src_sel == 3'd4 && rd_addr == 0) ? AW'(31) : rd_addr;
      m_write = reg_write && (src_sel < 3'd5);
      if (src_sel > 3'd4) m_err = 1;
      if (hilo_we) begin m_hi = hi_in; m_lo = lo_in; end
      m_pend = 1;
    end else if (!rf_stall) begin
      m_pend = 0;
    end
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    #1;
    check_all(tag);
    tick();
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [DW-1:0] data,
                       input logic [AW-1:0] rd, input logic rw, input logic hwe,
                       input logic [DW-1:0] hin, input logic stall);
    in_valid = v; src_sel = sel; alu_result = data; mem_dout = ~data; pc_link = data;
    rd_addr = rd; reg_write = rw; hilo_we = hwe; hi_in = hin; lo_in = hin + 1; rf_stall = stall;
  endtask

  initial begin
    m_pend = 0; m_write = 0; m_err = 0; m_addr = 0; m_data = 0; m_hi = 0; m_lo = 0;
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_hi", hi, 0);
    step("reset");

    // ALU write
    drive(1, 3'b000, 32'h0000_00A5, 8, 1, 0, 0, 0);
    step("alu_acc");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("alu_we", rf_we, 1);
    chk("alu_waddr", rf_waddr, 8);
    chk("alu_wdata", rf_wdata, 32'h0000_00A5);
    step("alu_out");

    // HI read returns the value before this transaction's own HI update
    drive(1, 3'b000, 0, 0, 0, 1, 32'h11, 0);
    step("hi_load");
    drive(1, 3'b010, 0, 5, 1, 1, 32'h22, 0);
    step("hi_read");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("hilo_wdata", rf_wdata, 32'h11);
    chk("hilo_hi", hi, 32'h22);
    chk("hilo_we", rf_we, 1);
    step("hilo_out");

    // Link write to r0 goes to LINK_REG
    drive(1, 3'b100, 32'h0040_0008, 0, 1, 0, 0, 0);
    step("link_acc");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("link_waddr", rf_waddr, 31);
    chk("link_wdata", rf_wdata, 32'h0040_0008);
    chk("link_we", rf_we, 1);
    step("link_out");

    // Stall for three cycles, then a single commit
    drive(1, 3'b000, 32'h77, 3, 1, 0, 0, 0);
    step("stall_acc");
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'b000, 32'h99, 9, 1, 0, 0, 1);
      #1;
      chk("stall_we", rf_we, 0);
      chk("stall_ready", in_ready, 0);
      chk("stall_wdata", rf_wdata, 32'h77);
      step("stall");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("release_we", rf_we, 1);
    chk("release_waddr", rf_waddr, 3);
    step("release");
    #1;
    chk("release_once", rf_we, 0);
    step("after_release");

    // Illegal select and r0 destination never write
    drive(1, 3'b111, 32'h5, 4, 1, 0, 0, 0);
    step("illegal_acc");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("illegal_we", rf_we, 0);
    chk("illegal_err", err_sel, 1);
    step("illegal_out");
    drive(1, 3'b000, 32'h6, 0, 1, 0, 0, 0);
    step("r0_acc");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("r0_we", rf_we, 0);
    chk("err_sticky", err_sel, 1);
    step("r0_out");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
            AW'($urandom_range(0, 31) < 4 ? 0 : $urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step("rand");
    end
    rst = 0;

    // Reset while a transaction is stalled in flight
    drive(1, 3'b111, 32'hAB, 7, 1, 1, 32'h5A, 0);
    step("mid_acc");
    drive(1, 3'b000, 32'hCD, 7, 1, 1, 32'h6B, 1);
    step("mid_stall");
    rst = 1;
    step("mid_rst");
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mid_we", rf_we, 0);
    chk("mid_hi", hi, 0);
    chk("mid_lo", lo, 0);
    chk("mid_err", err_sel, 0);
    chk("mid_ready", in_ready, 1);
    step("post_rst");

    chk("commit_count", dut_commits, exp_commits);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter ADDR_W, default 5, register-file address width.
REQ-003 SHALL have parameter LINK_REG, default 31, link register index for link writes.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream result present.
REQ-007 SHALL have port in_ready  output  1  stage can accept.
REQ-008 SHALL have port src_sel  input  3  source: 000 ALU, 001 mem, 010 HI, 011 LO, 100 link; others illegal.
REQ-009 SHALL have ports alu_result, mem_dout, pc_link  input  DATA_W  candidate write data.
REQ-010 SHALL have port rd_addr  input  ADDR_W  destination register.
REQ-011 SHALL have port reg_write  input  1  transaction writes register file.
REQ-012 SHALL have ports hilo_we  input  1, plus hi_in and lo_in  input  DATA_W  HI/LO update.
REQ-013 SHALL have port rf_stall  input  1  register file cannot commit this cycle.
REQ-014 SHALL have ports rf_we  output  1, rf_waddr  output  ADDR_W, rf_wdata  output  DATA_W.
REQ-015 SHALL have ports hi, lo  output  DATA_W  current HI/LO contents.
REQ-016 SHALL have port err_sel  output  1  sticky illegal-select flag.

Function
REQ-017 in_ready SHALL equal !out_valid_q || !rf_stall; accept = in_valid && in_ready.
REQ-018 On accept, SHALL register selected data, address, write flag, and set out_valid_q the next cycle (latency 1).
REQ-019 When out_valid_q && !rf_stall and no accept, SHALL clear out_valid_q; back-to-back accepts SHALL sustain 1 transaction/cycle.
REQ-020 Under rf_stall with out_valid_q set, SHALL hold rf_waddr/rf_wdata and the registered write flag unchanged.
REQ-021 rf_we SHALL equal out_valid_q && wflag_q && !rf_stall && (rf_waddr != 0).
REQ-022 src_sel 010/011 SHALL return HI/LO as held before this transaction's own hilo_we update.
REQ-023 On accept with hilo_we, SHALL load hi_in/lo_in into HI/LO at that clock edge, independent of reg_write.
REQ-024 src_sel 100 with rd_addr == 0 SHALL register LINK_REG as destination; otherwise rd_addr is used as given.
REQ-025 Illegal src_sel on accept SHALL register a zero write flag (no write) and set err_sel, which holds until reset.
REQ-026 in_valid low SHALL NOT alter HI/LO, err_sel or output registers.

Reset
REQ-027 On rst at clk edge: out_valid_q=0, rf_we=0, rf_waddr=0, rf_wdata=0, HI=0, LO=0, err_sel=0.
REQ-028 rst SHALL override a simultaneous accept; an in-flight transaction SHALL be discarded without writing.
REQ-029 in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-030 Macro WB_BYPASS_EN SHALL, when defined, add outputs fwd_valid (1), fwd_addr (ADDR_W) and fwd_data (DATA_W).
REQ-031 With WB_BYPASS_EN: fwd_valid = out_valid_q && wflag_q && (rf_waddr != 0), including stalled cycles; fwd_addr/fwd_data mirror rf_waddr/rf_wdata.
REQ-032 Without WB_BYPASS_EN: those ports SHALL be absent; all other behaviour identical.

Verification
REQ-033 ALU write: src_sel=000, alu_result=0x0000_00A5, rd_addr=8, reg_write=1 -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x0000_00A5.
REQ-034 HI/LO ordering: HI=0x11; accept hilo_we=1, hi_in=0x22, src_sel=010, reg_write=1 -> rf_wdata=0x11, hi=0x22 afterwards.
REQ-035 Link: src_sel=100, pc_link=0x0040_0008, rd_addr=0 -> rf_waddr=31, rf_wdata=0x0040_0008, rf_we=1.
REQ-036 Stall: hold rf_stall=1 for 3 cycles with out_valid_q set -> rf_we=0, data held, in_ready=0; release -> single rf_we pulse.
REQ-037 Illegal/r0: src_sel=111 -> rf_we never asserts, err_sel=1 until rst; rd_addr=0 with src_sel=000 -> rf_we=0.
REQ-038 Reset mid-flight: rst asserted while stalled -> next cycle rf_we=0, hi=lo=0, err_sel=0, in_ready=1.
